// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encodings and counter-width helper for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full adder cell driven by serial_adder
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first through one full_adder; SERIAL_ADDER_OVF_EN enables signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_nx;

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_sum_nx = WIDTH'({w_s, r_sum_sr} >> 1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: accept start only in IDLE, leave RUN on the last bit, DONE lasts one cycle
    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end

    // datapath: load operands on accept, shift one bit per RUN cycle, capture result on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_nx;
            r_carry  <= w_c;
            r_cnt    <= w_last ? r_cnt : r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_sum_nx;
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // overflow: carry into the MSB (still in r_carry on the last bit) versus carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_c;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8), honours SERIAL_ADDER_OVF_EN
module tb_serial_adder;

    localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   accepts[$];
    logic prev_busy = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (sum=%0h)", sum);
            end else begin
                m_e = q.pop_front();
                chk("sum", 32'(sum), 32'(m_e.sum));
                chk("cout", 32'(cout), 32'(m_e.cout));
                chk("ovf", 32'(ovf), 32'(m_e.ovf));
            end
        end
    end

    // acceptance tracker: cycle stamp of every busy rising edge
    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy === 1'b0) accepts.push_back(cyc);
        prev_busy = busy;
    end

    task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        int  lat;
        logic seen;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        q.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = done;
        end
        chk("latency", 32'(lat), 32'(W));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        run(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF);
        run(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF);
        run(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
        run(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);

        // start held high: operand change mid-RUN must not leak, re-accept after W+2 cycles
        accepts.delete();
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        q.push_back('{sum: 8'h10, cout: 1'b0, ovf: 1'b0});
        q.push_back('{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        repeat (4) @(negedge clk);
        a = 8'hFF;
        for (int i = 0; i < 30 && accepts.size() < 2; i++) @(negedge clk);
        start = 1'b0;
        chk("accept_count", 32'(accepts.size()), 32'd2);
        if (accepts.size() >= 2) chk("accept_spacing", 32'(accepts[1] - accepts[0]), 32'(W + 2));
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        chk("hold_drained", 32'(q.size()), 32'd0);

        // reset during RUN cycle 4 clears everything and yields no done
        run(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        run(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
